// File: rtl/vga_sync_gen_if.sv
// Output bundle of the VGA timing generator: pixel tick, coordinates, syncs and pulses.
// The rgb signal exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_sync_gen_if;
    logic       pix_tick;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       line_start;
    logic       frame_start;
`ifdef VGA_TEST_PATTERN_EN
    logic [7:0] rgb;
`endif

    modport master (
`ifdef VGA_TEST_PATTERN_EN
        output rgb,
`endif
        output pix_tick,
        output pix_x,
        output pix_y,
        output hsync,
        output vsync,
        output video_on,
        output line_start,
        output frame_start
    );

    modport slave (
`ifdef VGA_TEST_PATTERN_EN
        input  rgb,
`endif
        input  pix_tick,
        input  pix_x,
        input  pix_y,
        input  hsync,
        input  vsync,
        input  video_on,
        input  line_start,
        input  frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// 640x480@60Hz VGA timing generator on the master clock with a derived pixel-rate enable.
// Define VGA_TEST_PATTERN_EN to add the registered colour-bar output rgb.
module vga_sync_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic           clk,
    input  logic           clr_n,
    vga_sync_gen_if.master o_vga
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0]       V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0]       HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]       HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]       VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]       VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_tick;
    logic [9:0]       r_x;
    logic [9:0]       r_y;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_video_on;
    logic             r_line_start;
    logic             r_frame_start;

    logic [9:0]       w_x_next;
    logic [9:0]       w_y_next;
    logic             w_hs_next;
    logic             w_vs_next;
    logic             w_vo_next;

    // Next coordinates; only committed on a pixel tick.
    always_comb begin
        w_x_next = r_x + 10'd1;
        w_y_next = r_y;
        if (r_x == H_LAST) begin
            w_x_next = '0;
            if (r_y == V_LAST) begin
                w_y_next = '0;
            end else begin
                w_y_next = r_y + 10'd1;
            end
        end
    end

    assign w_hs_next = (w_x_next >= HS_FIRST) && (w_x_next <= HS_LAST);
    assign w_vs_next = (w_y_next >= VS_FIRST) && (w_y_next <= VS_LAST);
    assign w_vo_next = (w_x_next < H_VIS) && (w_y_next < V_VIS);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_div == DIV_LAST);
            if (r_div == DIV_LAST) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    // Syncs and video_on are decoded from the next coordinates so they land on the same edge.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_x           <= H_LAST;
            r_y           <= V_LAST;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_video_on    <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (r_tick) begin
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_hsync       <= w_hs_next ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= w_vs_next ? SYNC_POL : ~SYNC_POL;
            r_video_on    <= w_vo_next;
            r_line_start  <= (w_x_next == '0);
            r_frame_start <= (w_x_next == '0) && (w_y_next == '0);
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign o_vga.pix_tick    = r_tick;
    assign o_vga.pix_x       = r_x;
    assign o_vga.pix_y       = r_y;
    assign o_vga.hsync       = r_hsync;
    assign o_vga.vsync       = r_vsync;
    assign o_vga.video_on    = r_video_on;
    assign o_vga.line_start  = r_line_start;
    assign o_vga.frame_start = r_frame_start;

`ifdef VGA_TEST_PATTERN_EN
    // Eight equal-width bars across the visible line.
    localparam int unsigned BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

    logic [9:0] w_bar;
    logic [7:0] w_rgb_next;
    logic [7:0] r_rgb;

    assign w_bar = w_x_next / 10'(BAR_W);

    always_comb begin
        w_rgb_next = 8'h00;
        if (w_vo_next) begin
            case (w_bar)
                10'd0:   w_rgb_next = 8'hFF;
                10'd1:   w_rgb_next = 8'hFC;
                10'd2:   w_rgb_next = 8'h1F;
                10'd3:   w_rgb_next = 8'h1C;
                10'd4:   w_rgb_next = 8'hE3;
                10'd5:   w_rgb_next = 8'hE0;
                10'd6:   w_rgb_next = 8'h03;
                default: w_rgb_next = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_rgb <= 8'h00;
        end else if (r_tick) begin
            r_rgb <= w_rgb_next;
        end
    end

    assign o_vga.rgb = r_rgb;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: expected line/frame events are queued up front and a negedge monitor
// pops and checks them whenever a DUT raises line_start. Two instances: default and a small timing.
module tb_vga_sync_gen;

    typedef struct {
        int cyc;
        int y;
        bit fs;
        bit chk_line;
        int hs_clks;
        int vo_clks;
        bit chk_frame;
        int vs_clks;
        int px_cnt;
    } ev_t;

    logic clk;
    logic clr_n;
    int   cyc;
    bit   armed;
    int   n_vec;
    int   n_err;
    ev_t  fq[$];
    ev_t  sq[$];

    int   hs_cnt[2];
    int   vo_cnt[2];
    int   vs_cnt[2];
    int   px_cnt[2];
    int   mx_x[2];
    int   mx_y[2];
    logic prev_hs[2];
    logic prev_vs[2];

    vga_sync_gen_if f_if ();
    vga_sync_gen_if s_if ();

    vga_sync_gen u_full (
        .clk   (clk),
        .clr_n (clr_n),
        .o_vga (f_if)
    );

    // Small timing: H_TOTAL 25, V_TOTAL 15, so a frame is 750 clocks.
    vga_sync_gen #(
        .CLK_DIV  (2),
        .H_ACTIVE (16),
        .H_FP     (2),
        .H_SYNC   (4),
        .H_BP     (3),
        .V_ACTIVE (8),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (3),
        .SYNC_POL (1'b0)
    ) u_small (
        .clk   (clk),
        .clr_n (clr_n),
        .o_vga (s_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            if (!clr_n) cyc = 0;
            else        cyc = cyc + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
        end
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 2; i++) begin
            hs_cnt[i]  = 0;
            vo_cnt[i]  = 0;
            vs_cnt[i]  = 0;
            px_cnt[i]  = 0;
            mx_x[i]    = 0;
            mx_y[i]    = 0;
            prev_hs[i] = 1'b1;
            prev_vs[i] = 1'b1;
        end
    endtask

    // Line k starts 3 clocks after release (divider, tick, wrap) plus k line periods.
    task automatic push_events(input int lim);
        ev_t e;
        fq.delete();
        sq.delete();
        for (int k = 0; 3 + k * 1600 <= lim; k++) begin
            e.cyc       = 3 + k * 1600;
            e.y         = k % 525;
            e.fs        = (e.y == 0);
            e.chk_line  = (k > 0);
            e.hs_clks   = 192;
            e.vo_clks   = (((k + 524) % 525) < 480) ? 1280 : 0;
            e.chk_frame = e.fs && (k > 0);
            e.vs_clks   = 3200;
            e.px_cnt    = 307200;
            fq.push_back(e);
        end
        for (int k = 0; 3 + k * 50 <= lim; k++) begin
            e.cyc       = 3 + k * 50;
            e.y         = k % 15;
            e.fs        = (e.y == 0);
            e.chk_line  = (k > 0);
            e.hs_clks   = 8;
            e.vo_clks   = (((k + 14) % 15) < 8) ? 32 : 0;
            e.chk_frame = e.fs && (k > 0);
            e.vs_clks   = 100;
            e.px_cnt    = 128;
            sq.push_back(e);
        end
    endtask

    task automatic mon(input int id, input string t, input logic tick, input logic [9:0] x,
                       input logic [9:0] y, input logic hs, input logic vs, input logic vo,
                       input logic ls, input logic fs, input int hs_x, input int vs_y);
        ev_t e;
        bit  got;
        got = 1'b0;
        if (ls) begin
            if (id == 0 && fq.size() > 0) begin
                e   = fq.pop_front();
                got = 1'b1;
            end else if (id == 1 && sq.size() > 0) begin
                e   = sq.pop_front();
                got = 1'b1;
            end
            if (!got) begin
                n_vec++;
                n_err++;
                $display("FAIL %s_unexpected_line_start: got event at cyc %0d expected none", t, cyc);
            end else begin
                check({t, "_ls_cyc"}, cyc, e.cyc);
                check({t, "_ls_x"}, int'(x), 0);
                check({t, "_ls_y"}, int'(y), e.y);
                check({t, "_ls_fs"}, int'(fs), int'(e.fs));
                if (e.chk_line) begin
                    check({t, "_hsync_clks"}, hs_cnt[id], e.hs_clks);
                    check({t, "_video_on_clks"}, vo_cnt[id], e.vo_clks);
                end
                if (e.chk_frame) begin
                    check({t, "_vsync_clks"}, vs_cnt[id], e.vs_clks);
                    check({t, "_video_pixels"}, px_cnt[id], e.px_cnt);
                end
            end
            hs_cnt[id] = 0;
            vo_cnt[id] = 0;
            if (fs) begin
                vs_cnt[id] = 0;
                px_cnt[id] = 0;
            end
        end
        if (fs) check({t, "_fs_with_ls"}, int'(ls), 1);
        if (!hs) hs_cnt[id]++;
        if (vo) vo_cnt[id]++;
        if (!vs) vs_cnt[id]++;
        if (tick && vo) px_cnt[id]++;
        if (!hs && prev_hs[id]) check({t, "_hsync_start_x"}, int'(x), hs_x);
        if (!vs && prev_vs[id]) begin
            check({t, "_vsync_start_x"}, int'(x), 0);
            check({t, "_vsync_start_y"}, int'(y), vs_y);
        end
        prev_hs[id] = hs;
        prev_vs[id] = vs;
        if (int'(x) > mx_x[id]) mx_x[id] = int'(x);
        if (int'(y) > mx_y[id]) mx_y[id] = int'(y);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (armed && clr_n) begin
                mon(0, "full", f_if.pix_tick, f_if.pix_x, f_if.pix_y, f_if.hsync, f_if.vsync,
                    f_if.video_on, f_if.line_start, f_if.frame_start, 656, 490);
                mon(1, "small", s_if.pix_tick, s_if.pix_x, s_if.pix_y, s_if.hsync, s_if.vsync,
                    s_if.video_on, s_if.line_start, s_if.frame_start, 18, 10);
`ifdef VGA_TEST_PATTERN_EN
                if (f_if.pix_tick && f_if.pix_y == 10'd0) begin
                    case (int'(f_if.pix_x))
                        0:   check("rgb_x0", int'(f_if.rgb), 'hFF);
                        85:  check("rgb_x85", int'(f_if.rgb), 'hFC);
                        160: check("rgb_x160", int'(f_if.rgb), 'h1F);
                        250: check("rgb_x250", int'(f_if.rgb), 'h1C);
                        330: check("rgb_x330", int'(f_if.rgb), 'hE3);
                        400: check("rgb_x400", int'(f_if.rgb), 'hE0);
                        500: check("rgb_x500", int'(f_if.rgb), 'h03);
                        600: check("rgb_x600", int'(f_if.rgb), 'h00);
                        639: check("rgb_x639", int'(f_if.rgb), 'h00);
                        700: check("rgb_x700", int'(f_if.rgb), 'h00);
                        default: ;
                    endcase
                end
`endif
            end
        end
    end

    task automatic chk_rst(input string t, input logic tick, input logic [9:0] x,
                           input logic [9:0] y, input logic hs, input logic vs, input logic vo,
                           input logic ls, input logic fs, input int xl, input int yl);
        check({t, "_rst_tick"}, int'(tick), 0);
        check({t, "_rst_x"}, int'(x), xl);
        check({t, "_rst_y"}, int'(y), yl);
        check({t, "_rst_hsync"}, int'(hs), 1);
        check({t, "_rst_vsync"}, int'(vs), 1);
        check({t, "_rst_video_on"}, int'(vo), 0);
        check({t, "_rst_line_start"}, int'(ls), 0);
        check({t, "_rst_frame_start"}, int'(fs), 0);
    endtask

    task automatic chk_rst_all();
        chk_rst("full", f_if.pix_tick, f_if.pix_x, f_if.pix_y, f_if.hsync, f_if.vsync,
                f_if.video_on, f_if.line_start, f_if.frame_start, 799, 524);
        chk_rst("small", s_if.pix_tick, s_if.pix_x, s_if.pix_y, s_if.hsync, s_if.vsync,
                s_if.video_on, s_if.line_start, s_if.frame_start, 24, 14);
`ifdef VGA_TEST_PATTERN_EN
        check("full_rst_rgb", int'(f_if.rgb), 0);
`endif
    endtask

    initial begin
        bit found;
        clr_n = 1'b0;
        armed = 1'b0;
        n_vec = 0;
        n_err = 0;
        clear_mon();

        repeat (3) @(negedge clk);
        #1;
        chk_rst_all();
        push_events(3300);
        @(negedge clk);
        #2;
        clr_n = 1'b1;
        armed = 1'b1;

        @(negedge clk);
        check("full_tick_edge1", int'(f_if.pix_tick), 0);
        check("full_x_edge1", int'(f_if.pix_x), 799);
        @(negedge clk);
        check("full_tick_edge2", int'(f_if.pix_tick), 1);
        check("full_x_edge2", int'(f_if.pix_x), 799);
        @(negedge clk);
        check("full_video_on_first", int'(f_if.video_on), 1);

        while (cyc < 3300) @(negedge clk);
        armed = 1'b0;
        check("full_queue_left", fq.size(), 0);
        check("small_queue_left", sq.size(), 0);
        check("full_max_x", mx_x[0], 799);
        check("small_max_x", mx_x[1], 24);
        check("small_max_y", mx_y[1], 14);

        // Reset asserted between edges at a mid-frame position of the small instance.
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (s_if.pix_x == 10'd10 && s_if.pix_y == 10'd5) found = 1'b1;
        end
        check("midframe_position_reached", int'(found), 1);
        #2;
        clr_n = 1'b0;
        #1;
        chk_rst_all();

        repeat (2) @(negedge clk);
        clear_mon();
        push_events(1700);
        #2;
        clr_n = 1'b1;
        armed = 1'b1;
        while (cyc < 1700) @(negedge clk);
        armed = 1'b0;
        check("full_queue_left_2", fq.size(), 0);
        check("small_queue_left_2", sq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
